// File: rtl/divu_hilo_unit.sv
// Multi-cycle restoring unsigned divider that owns the HI (remainder) and LO (quotient) registers.
// Optional DivZero flag output is enabled by defining DIVU_DIVZERO_FLAG_EN.
module divu_hilo_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  DIVU_CODE = 6'b011011,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done
`ifdef DIVU_DIVZERO_FLAG_EN
  ,
  output logic             DivZero
`endif
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     shifted;
  logic               start;

  assign start = (Signal == DIVU_CODE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Remainder gains one extra bit so the compare sees the carry out of the shift.
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          quo_d   = dataA;
          dvs_d   = dataB;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StCalc: begin
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = shifted - {1'b0, dvs_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        hi_d    = rem_q[WIDTH-1:0];
        lo_d    = quo_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

`ifdef DIVU_DIVZERO_FLAG_EN
  logic div_zero_q, div_zero_d;

  always_comb begin
    div_zero_d = div_zero_q;
    if (state_q == StIdle && start) begin
      div_zero_d = (dataB == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
    end
  end

  assign DivZero = div_zero_q;
`endif

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed self-checking bench for divu_hilo_unit: latency, HI/LO hold, busy-ignore, resets.
module tb_divu_hilo_unit;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        Busy;
  logic        Done;
`ifdef DIVU_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  int          total;
  int          bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  divu_hilo_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .Busy   (Busy),
    .Done   (Done)
`ifdef DIVU_DIVZERO_FLAG_EN
    ,
    .DivZero(div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start a divide at edge 0, optionally re-issue DIVU at edge inj, then check edges 1..34.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int inj);
    logic stable;
    Signal = DIVU;
    dataA  = a;
    dataB  = b;
    @(posedge clk); #1;
    Signal = 6'h00;
    dataA  = $urandom;
    dataB  = $urandom;
    chk({tag, "_busy_e0"}, 32'(Busy), 32'd1);
    chk({tag, "_done_e0"}, 32'(Done), 32'd0);
`ifdef DIVU_DIVZERO_FLAG_EN
    chk({tag, "_divzero"}, 32'(div_zero), (b == 32'd0) ? 32'd1 : 32'd0);
`endif
    stable = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      if (e == inj) begin
        Signal = DIVU;
        dataA  = 32'd9;
        dataB  = 32'd2;
      end
      @(posedge clk); #1;
      Signal = 6'h00;
      if (!Busy || Done || HiOut !== exp_hi || LoOut !== exp_lo) stable = 1'b0;
    end
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_busy_e33"}, 32'(Busy), 32'd0);
    chk({tag, "_done_e33"}, 32'(Done), 32'd1);
    chk({tag, "_lo"}, LoOut, eq);
    chk({tag, "_hi"}, HiOut, er);
    exp_hi = er;
    exp_lo = eq;
    @(posedge clk); #1;
    chk({tag, "_done_e34"}, 32'(Done), 32'd0);
  endtask

  initial begin
    logic seen;
    total  = 0;
    bad    = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    rst_n  = 1'b0;
    Signal = 6'h00;
    dataA  = 32'd0;
    dataB  = 32'd0;
    #3;
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    run_div("d7_9", 32'd7, 32'd9, 32'd0, 32'd7, 0);
    run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
    run_div("d50_5_inj", 32'd50, 32'd5, 32'd10, 32'd0, 10);

    // Asynchronous reset between edges clears LO (currently 10) with no clock.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lo", LoOut, 32'd0);
    chk("arst_hi", HiOut, 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    // Abort a divide mid-flight, then confirm it never completes.
    Signal = DIVU;
    dataA  = 32'd50;
    dataB  = 32'd5;
    @(posedge clk); #1;
    Signal = 6'h00;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_pre", 32'(Busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_div("d9_2", 32'd9, 32'd2, 32'd4, 32'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
